game_tick_gen: RTL and testbench

Downstream consumer of the game-speed selector. It converts the 2-bit `GameSpeed` code into a periodic one-cycle `Tick` strobe that paces the game logic. Period is a parameterised number of milliseconds per speed. Run/pause and restart controls come from the game controller, and speed changes take effect only at tick boundaries, so a period is never truncated.

---
 rtl/game_tick_gen_if.sv | 32 +++
 rtl/game_tick_gen.sv | 157 +++++++++++++++
 tb/tb_game_tick_gen.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_tick_gen_if.sv
// Control/status bundle between the game controller and the tick generator.
// The master side drives speed and run controls; the slave side returns the
// tick strobe and the status it maintains.
interface game_tick_gen_if;
    logic [1:0] GameSpeed;
    logic       Run;
    logic       Restart;
    logic       Tick;
    logic [7:0] TickCount;
    logic [1:0] ActiveSpeed;
    logic       Running;

    modport master (
        output GameSpeed,
        output Run,
        output Restart,
        input  Tick,
        input  TickCount,
        input  ActiveSpeed,
        input  Running
    );

    modport slave (
        input  GameSpeed,
        input  Run,
        input  Restart,
        output Tick,
        output TickCount,
        output ActiveSpeed,
        output Running
    );
endinterface

// File: rtl/game_tick_gen.sv
// Game tick generator: a millisecond prescaler feeds a millisecond counter
// whose terminal count depends on the speed latched at the last period
// boundary. Emits a one-cycle Tick at each period end and counts ticks.
// Speed changes are only adopted on a terminal edge so that no period is
// ever cut short. Run pauses time, Restart clears everything.
module game_tick_gen #(
    parameter int CLK_PER_MS       = 50000,
    parameter int PERIOD_NORMAL_MS = 1000,
    parameter int PERIOD_INTER_MS  = 500,
    parameter int PERIOD_ADV_MS    = 250
) (
    input  logic            Clock,
    input  logic            Reset,
    game_tick_gen_if.slave  bus
);

    // PreCount holds 0..CLK_PER_MS-1; MsCount is sized by the longest period,
    // which the other two periods must not exceed.
    localparam int PRE_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int MS_W  = (PERIOD_NORMAL_MS > 1) ? $clog2(PERIOD_NORMAL_MS) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(CLK_PER_MS - 1);
    localparam logic [PRE_W-1:0] PRE_ZERO    = PRE_W'(0);
    localparam logic [PRE_W-1:0] PRE_ONE     = PRE_W'(1);
    localparam logic [MS_W-1:0]  MS_ZERO     = MS_W'(0);
    localparam logic [MS_W-1:0]  MS_ONE      = MS_W'(1);
    localparam logic [MS_W-1:0]  P_NORMAL_M1 = MS_W'(PERIOD_NORMAL_MS - 1);
    localparam logic [MS_W-1:0]  P_INTER_M1  = MS_W'(PERIOD_INTER_MS - 1);
    localparam logic [MS_W-1:0]  P_ADV_M1    = MS_W'(PERIOD_ADV_MS - 1);

    typedef enum logic [1:0] {
        S_STOPPED = 2'd0,
        S_RUNNING = 2'd1,
        S_PAUSED  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic [PRE_W-1:0]  pre_count_r;
    logic [PRE_W-1:0]  pre_count_nxt_s;
    logic [MS_W-1:0]   ms_count_r;
    logic [MS_W-1:0]   ms_count_nxt_s;
    logic              tick_r;
    logic              tick_nxt_s;
    logic [7:0]        tick_count_r;
    logic [7:0]        tick_count_nxt_s;
    logic [1:0]        active_speed_r;
    logic [1:0]        active_speed_nxt_s;
    logic              running_r;
    logic [MS_W-1:0]   period_m1_s;
    logic              count_en_s;
    logic              pre_term_s;
    logic              ms_term_s;

    // Time advances in Running and on the Paused->Running edge.
    assign count_en_s = (state_r != S_STOPPED) && bus.Run;
    assign pre_term_s = (pre_count_r == PRE_LAST);
    assign ms_term_s  = (ms_count_r == period_m1_s);

    // Period terminal value selected by the speed governing this period.
    always_comb begin
        period_m1_s = P_NORMAL_M1;
        case (bus.ActiveSpeed)
            2'b00:   period_m1_s = P_NORMAL_M1;
            2'b01:   period_m1_s = P_INTER_M1;
            default: period_m1_s = P_ADV_M1;
        endcase
    end

    // State register plus all registered outputs and counters.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_r        <= S_STOPPED;
            pre_count_r    <= PRE_ZERO;
            ms_count_r     <= MS_ZERO;
            tick_r         <= 1'b0;
            tick_count_r   <= 8'd0;
            active_speed_r <= 2'b00;
            running_r      <= 1'b0;
        end else begin
            state_r        <= next_state_s;
            pre_count_r    <= pre_count_nxt_s;
            ms_count_r     <= ms_count_nxt_s;
            tick_r         <= tick_nxt_s;
            tick_count_r   <= tick_count_nxt_s;
            active_speed_r <= active_speed_nxt_s;
            running_r      <= (next_state_s == S_RUNNING);
        end
    end

    // Next-state logic: Restart forces Stopped, otherwise Run drives the moves.
    always_comb begin
        next_state_s = state_r;
        if (bus.Restart) begin
            next_state_s = S_STOPPED;
        end else begin
            case (state_r)
                S_STOPPED: begin
                    if (bus.Run) next_state_s = S_RUNNING;
                    else         next_state_s = S_STOPPED;
                end
                S_RUNNING: begin
                    if (bus.Run) next_state_s = S_RUNNING;
                    else         next_state_s = S_PAUSED;
                end
                S_PAUSED: begin
                    if (bus.Run) next_state_s = S_RUNNING;
                    else         next_state_s = S_PAUSED;
                end
                default: next_state_s = S_STOPPED;
            endcase
        end
    end

    // Output/datapath logic: next counter values, tick strobe and speed latch.
    always_comb begin
        pre_count_nxt_s    = pre_count_r;
        ms_count_nxt_s     = ms_count_r;
        tick_nxt_s         = 1'b0;
        tick_count_nxt_s   = tick_count_r;
        active_speed_nxt_s = active_speed_r;
        if (bus.Restart) begin
            // Same clear as reset; a coincident terminal count is discarded.
            pre_count_nxt_s    = PRE_ZERO;
            ms_count_nxt_s     = MS_ZERO;
            tick_count_nxt_s   = 8'd0;
            active_speed_nxt_s = 2'b00;
        end else if (state_r == S_STOPPED) begin
            // Start edge loads the speed but does not count.
            if (bus.Run) active_speed_nxt_s = bus.GameSpeed;
            else         active_speed_nxt_s = active_speed_r;
        end else if (count_en_s) begin
            if (pre_term_s) begin
                pre_count_nxt_s = PRE_ZERO;
                if (ms_term_s) begin
                    ms_count_nxt_s     = MS_ZERO;
                    tick_nxt_s         = 1'b1;
                    tick_count_nxt_s   = tick_count_r + 8'd1;
                    active_speed_nxt_s = bus.GameSpeed;
                end else begin
                    ms_count_nxt_s = ms_count_r + MS_ONE;
                end
            end else begin
                pre_count_nxt_s = pre_count_r + PRE_ONE;
            end
        end else begin
            // Paused: everything holds, including a deferred speed change.
            pre_count_nxt_s = pre_count_r;
        end
    end

    assign bus.Tick        = tick_r;
    assign bus.TickCount   = tick_count_r;
    assign bus.ActiveSpeed = active_speed_r;
    assign bus.Running     = running_r;

endmodule

// File: tb/tb_game_tick_gen.sv
// Directed bench for game_tick_gen with CLK_PER_MS=4 and periods 8/4/2 ms,
// i.e. tick periods of 32, 16 and 8 clocks.
module tb_game_tick_gen;

    logic Clock;
    logic Reset;
    int   errors;
    int   checks;

    game_tick_gen_if bus ();

    game_tick_gen #(
        .CLK_PER_MS       (4),
        .PERIOD_NORMAL_MS (8),
        .PERIOD_INTER_MS  (4),
        .PERIOD_ADV_MS    (2)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Edges until Tick is seen (1-based), or -1 if the budget runs out.
    task automatic wait_tick(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (bus.Tick === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_restart();
        bus.Restart = 1'b1;
        step();
        bus.Restart = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        bus.Run = 1'b0;
        bus.Restart = 1'b0;
        bus.GameSpeed = 2'b00;
        step();
        step();
        checks++;
        if ({bus.Tick, bus.TickCount, bus.ActiveSpeed, bus.Running} !== 12'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, expected all zero",
                     {bus.Tick, bus.TickCount, bus.ActiveSpeed, bus.Running});
        end
        Reset = 1'b1;
        step();
    endtask

    task automatic test_first_tick();
        int n;
        bus.GameSpeed = 2'b00;
        bus.Run = 1'b1;
        step();
        checks++;
        if (bus.Running !== 1'b1) begin
            errors++;
            $display("FAIL start_running: got %b, expected 1", bus.Running);
        end
        wait_tick(100, n);
        checks++;
        if (n + 1 !== 33) begin
            errors++;
            $display("FAIL first_tick_latency: got %0d, expected 33", n + 1);
        end
        checks++;
        if (bus.TickCount !== 8'd1) begin
            errors++;
            $display("FAIL tick_count_1: got %0d, expected 1", bus.TickCount);
        end
        for (int k = 2; k <= 3; k++) begin
            wait_tick(100, n);
            checks++;
            if (n !== 32) begin
                errors++;
                $display("FAIL normal_period_%0d: got %0d, expected 32", k, n);
            end
            checks++;
            if (bus.TickCount !== 8'(k)) begin
                errors++;
                $display("FAIL tick_count_%0d: got %0d, expected %0d", k, bus.TickCount, k);
            end
        end
        step();
        checks++;
        if (bus.Tick !== 1'b0 || bus.Running !== 1'b1) begin
            errors++;
            $display("FAIL tick_width: tick=%b running=%b, expected 0/1", bus.Tick, bus.Running);
        end
    endtask

    task automatic test_speed_change();
        int n;
        do_restart();
        bus.GameSpeed = 2'b01;
        step();
        wait_tick(100, n);
        checks++;
        if (n !== 16 || bus.ActiveSpeed !== 2'b01) begin
            errors++;
            $display("FAIL inter_first: got %0d/%b, expected 16/01", n, bus.ActiveSpeed);
        end
        repeat (5) step();
        bus.GameSpeed = 2'b10;
        step();
        checks++;
        if (bus.ActiveSpeed !== 2'b01) begin
            errors++;
            $display("FAIL speed_deferred: got %b, expected 01", bus.ActiveSpeed);
        end
        wait_tick(100, n);
        checks++;
        if (n + 6 !== 16) begin
            errors++;
            $display("FAIL inter_period_kept: got %0d, expected 16", n + 6);
        end
        checks++;
        if (bus.ActiveSpeed !== 2'b10) begin
            errors++;
            $display("FAIL speed_adopted: got %b, expected 10", bus.ActiveSpeed);
        end
        wait_tick(100, n);
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL adv_period: got %0d, expected 8", n);
        end
    endtask

    task automatic test_pause();
        int n;
        do_restart();
        bus.GameSpeed = 2'b00;
        step();
        wait_tick(100, n);
        repeat (10) step();
        bus.Run = 1'b0;
        step();
        checks++;
        if (bus.Running !== 1'b0) begin
            errors++;
            $display("FAIL paused_running: got %b, expected 0", bus.Running);
        end
        repeat (4) step();
        bus.Run = 1'b1;
        wait_tick(100, n);
        checks++;
        if (n + 15 !== 37) begin
            errors++;
            $display("FAIL pause_delay: got %0d, expected 37", n + 15);
        end
        checks++;
        if (bus.TickCount !== 8'd2) begin
            errors++;
            $display("FAIL pause_count: got %0d, expected 2", bus.TickCount);
        end
    endtask

    task automatic test_restart_terminal();
        int n;
        logic seen;
        do_restart();
        bus.GameSpeed = 2'b10;
        step();
        seen = 1'b0;
        repeat (7) begin
            step();
            if (bus.Tick === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL early_tick: got tick before terminal, expected none");
        end
        bus.Restart = 1'b1;
        step();
        bus.Restart = 1'b0;
        checks++;
        if ({bus.Tick, bus.TickCount, bus.ActiveSpeed, bus.Running} !== 12'd0) begin
            errors++;
            $display("FAIL restart_on_terminal: got %b, expected all zero",
                     {bus.Tick, bus.TickCount, bus.ActiveSpeed, bus.Running});
        end
        wait_tick(100, n);
        checks++;
        if (n !== 9 || bus.TickCount !== 8'd1) begin
            errors++;
            $display("FAIL restart_retime: got %0d/%0d, expected 9/1", n, bus.TickCount);
        end
    endtask

    task automatic test_wrap();
        int n;
        do_restart();
        bus.GameSpeed = 2'b11;
        wait_tick(100, n);
        checks++;
        if (n !== 9) begin
            errors++;
            $display("FAIL wrap_first: got %0d, expected 9", n);
        end
        for (int k = 2; k <= 256; k++) begin
            wait_tick(100, n);
            checks++;
            if (n !== 8) begin
                errors++;
                $display("FAIL wrap_period_%0d: got %0d, expected 8", k, n);
            end
            if (k == 255) begin
                checks++;
                if (bus.TickCount !== 8'd255) begin
                    errors++;
                    $display("FAIL count_255: got %0d, expected 255", bus.TickCount);
                end
            end
        end
        checks++;
        if (bus.TickCount !== 8'd0 || bus.ActiveSpeed !== 2'b11) begin
            errors++;
            $display("FAIL count_wrap: got %0d/%b, expected 0/11", bus.TickCount, bus.ActiveSpeed);
        end
    endtask

    task automatic test_reset_midperiod();
        int n;
        repeat (3) step();
        Reset = 1'b0;
        step();
        checks++;
        if ({bus.Tick, bus.TickCount, bus.ActiveSpeed, bus.Running} !== 12'd0) begin
            errors++;
            $display("FAIL reset_midperiod: got %b, expected all zero",
                     {bus.Tick, bus.TickCount, bus.ActiveSpeed, bus.Running});
        end
        Reset = 1'b1;
        bus.GameSpeed = 2'b01;
        wait_tick(100, n);
        checks++;
        if (n !== 17 || bus.ActiveSpeed !== 2'b01) begin
            errors++;
            $display("FAIL reset_restart_timing: got %0d/%b, expected 17/01", n, bus.ActiveSpeed);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_first_tick();
        test_speed_change();
        test_pause();
        test_restart_terminal();
        test_wrap();
        test_reset_midperiod();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
